// File: rtl/ins_loader_pkg.sv
// Shared definitions for the instruction loader: field widths, opcode encodings
// and loader FSM states.
package ins_loader_pkg;

  localparam int unsigned OPCODE_WIDTH = 3;
  localparam int unsigned ADDR_WIDTH   = 10;

  function automatic int unsigned ins_width(input int unsigned aw);
    return OPCODE_WIDTH + 3 * aw;
  endfunction

  function automatic int unsigned bytes_per_ins(input int unsigned w);
    return (w + 7) / 8;
  endfunction

  localparam int unsigned INS_WIDTH     = ins_width(ADDR_WIDTH);
  localparam int unsigned BYTES_PER_INS = bytes_per_ins(INS_WIDTH);

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_MUL   = 3'b011,
    OP_DOTS  = 3'b100,
    OP_DOTA  = 3'b101,
    OP_PASSB = 3'b110
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } ldr_state_t;

endpackage

// File: rtl/ins_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = host/memory side, slave = loader.
interface ins_loader_if
  import ins_loader_pkg::*;
#(
  parameter int unsigned INS_ADDR_WIDTH = 10,
  parameter int unsigned INS_W          = ins_loader_pkg::INS_WIDTH
);

  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      ins_we;
  logic [INS_ADDR_WIDTH-1:0] ins_waddr;
  logic [INS_W-1:0]          ins_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  ins_we,
    input  ins_waddr,
    input  ins_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output ins_we,
    output ins_waddr,
    output ins_wdata
  );

endinterface

// File: rtl/ins_byte_packer.sv
// Little-endian byte packer: shifts stream bytes into one instruction word and
// flags the final byte of each instruction.
module ins_byte_packer
  import ins_loader_pkg::*;
#(
  parameter int unsigned INS_W = ins_loader_pkg::INS_WIDTH,
  parameter int unsigned BPI   = bytes_per_ins(INS_W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_shift,
  input  logic [7:0]       i_byte,
  output logic             o_last,
  output logic [INS_W-1:0] o_word
);

  localparam int unsigned IDX_W = $clog2(BPI);
  localparam int unsigned BUF_W = (BPI - 1) * 8;

  logic [IDX_W-1:0] r_idx;
  logic [BUF_W-1:0] r_buf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (i_shift) begin
      r_buf <= {i_byte, r_buf[BUF_W-1:8]};
      r_idx <= o_last ? '0 : r_idx + 1'b1;
    end
  end

  assign o_last = (r_idx == IDX_W'(BPI - 1));
  // Word is valid while the last byte is presented, so the loader can register
  // it on the accepting edge and pulse the write one cycle later.
  assign o_word = INS_W'({i_byte, r_buf});

endmodule

// File: rtl/ins_loader.sv
// Instruction-memory loader: parses header + packed instructions, writes them
// from address 0 and holds the core in reset until the load completes.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int unsigned INS_ADDR_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH     = ins_loader_pkg::ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_start,
  ins_loader_if.slave  bus,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic         o_core_rstn
);

  localparam int unsigned INS_W = ins_width(ADDR_WIDTH);
  localparam int unsigned BPI   = bytes_per_ins(INS_W);
  localparam logic [16:0] DEPTH = 17'(2 ** INS_ADDR_WIDTH);

  ldr_state_t                r_state;
  logic [15:0]               r_count;
  logic [INS_ADDR_WIDTH-1:0] r_addr;
  logic                      r_rx_ready;
  logic                      r_we;
  logic [INS_ADDR_WIDTH-1:0] r_waddr;
  logic [INS_W-1:0]          r_wdata;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;
  logic                      r_core_rstn;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic [INS_W-1:0] w_word;
  logic [15:0]      w_hdr_count;
  logic             w_last_addr;

  assign w_accept    = bus.rx_valid && r_rx_ready;
  assign w_shift     = w_accept && (r_state == DATA);
  assign w_hdr_count = {bus.rx_data, r_count[7:0]};
  // 16-bit compare so a full-depth load ends before the address register wraps.
  assign w_last_addr = (16'(r_addr) == (r_count - 16'd1));

  ins_byte_packer #(
    .INS_W (INS_W),
    .BPI   (BPI)
  ) u_packer (
    .clk     (clk),
    .rstn    (rstn),
    .i_shift (w_shift),
    .i_byte  (bus.rx_data),
    .o_last  (w_last),
    .o_word  (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_addr      <= '0;
      r_rx_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_core_rstn <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            r_state     <= HDR0;
            r_addr      <= '0;
            r_rx_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_core_rstn <= 1'b0;
          end
        end
        HDR0: begin
          if (w_accept) begin
            r_count[7:0] <= bus.rx_data;
            r_state      <= HDR1;
          end
        end
        HDR1: begin
          if (w_accept) begin
            r_count <= w_hdr_count;
            if (w_hdr_count == 16'd0) begin
              r_state     <= DONE;
              r_rx_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_core_rstn <= 1'b1;
            end else if ({1'b0, w_hdr_count} > DEPTH) begin
              r_state    <= ERR;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_shift && w_last) begin
            r_state    <= WRITE;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b1;
            r_waddr    <= r_addr;
            r_wdata    <= w_word;
          end
        end
        WRITE: begin
          if (w_last_addr) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_core_rstn <= 1'b1;
          end else begin
            r_state    <= DATA;
            r_addr     <= r_addr + 1'b1;
            r_rx_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.ins_we    = r_we;
  assign bus.ins_waddr = r_waddr;
  assign bus.ins_wdata = r_wdata;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_core_rstn   = r_core_rstn;

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: table of instruction vectors, write
// scoreboard, and directed sequences for header, error, abort and restart cases.
module tb_ins_loader;
  import ins_loader_pkg::*;

  localparam int unsigned IAW  = 10;
  localparam int unsigned IW   = INS_WIDTH;
  localparam int unsigned NVEC = 5;

  typedef struct packed {
    logic [39:0]   bytes_le;
    logic [IW-1:0] word;
  } vec_t;

  typedef struct packed {
    logic [IAW-1:0] a;
    logic [IW-1:0]  d;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic busy, done, err, core_rstn;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_writes = 0;

  vec_t tbl [NVEC];
  exp_t sb [$];

  ins_loader_if #(.INS_ADDR_WIDTH(IAW), .INS_W(IW)) bus ();

  ins_loader #(
    .INS_ADDR_WIDTH (IAW),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_start     (start),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_core_rstn (core_rstn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn && bus.ins_we) begin
      n_writes++;
      check("we_rx_ready", 64'(bus.rx_ready), 64'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                 bus.ins_waddr, bus.ins_wdata);
      end else begin
        e = sb.pop_front();
        check("waddr", 64'(bus.ins_waddr), 64'(e.a));
        check("wdata", 64'(bus.ins_wdata), 64'(e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned idle;
    bit ok;
    idle = (gap == 0) ? 0 : $urandom_range(gap, 0);
    repeat (idle) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rx_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_accept_timeout: byte %0h not accepted, expected rx_ready within 100 cycles", b);
    end
  endtask

  task automatic send_hdr(input logic [15:0] cnt, input int unsigned gap);
    send_byte(cnt[7:0], gap);
    send_byte(cnt[15:8], gap);
  endtask

  task automatic push_exp(input int unsigned k, input logic [IAW-1:0] addr);
    exp_t e;
    e.a = addr;
    e.d = tbl[k].word;
    sb.push_back(e);
  endtask

  task automatic send_ins(input int unsigned k, input logic [IAW-1:0] addr, input int unsigned gap);
    logic [39:0] bl;
    bl = tbl[k].bytes_le;
    push_exp(k, addr);
    for (int j = 0; j < 5; j++) send_byte(bl[j*8 +: 8], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic load_prog(input int unsigned n, input int unsigned gap);
    pulse_start();
    send_hdr(n[15:0], gap);
    for (int unsigned i = 0; i < n; i++) send_ins(i % NVEC, i[IAW-1:0], gap);
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [IW-1:0] w;
    logic [39:0]   bl;
    int unsigned   w0;

    tbl[0] = '{bytes_le: 40'h00_0000_0409, word: 33'h0_0000_0409};
    tbl[1] = '{bytes_le: 40'h00_0010_0013, word: 33'h0_0010_0013};
    tbl[2] = '{bytes_le: 40'hff_ffff_ffff, word: 33'h1_ffff_ffff};
    w = {10'h3ff, 10'h000, 10'h155, OP_DOTA};
    tbl[3] = '{bytes_le: {7'b1010101, w}, word: w};
    w = {10'h001, 10'h2aa, 10'h0f0, OP_PASSB};
    tbl[4] = '{bytes_le: {7'h00, w}, word: w};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_ins_we", 64'(bus.ins_we), 64'd0);
    check("rst_flags", 64'({busy, done, err, core_rstn}), 64'd0);
    check("rst_waddr", 64'(bus.ins_waddr), 64'd0);
    check("rst_wdata", 64'(bus.ins_wdata), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Two-instruction load, back-to-back bytes
    pulse_start();
    check("t1_hdr0_busy", 64'(busy), 64'd1);
    check("t1_hdr0_rx_ready", 64'(bus.rx_ready), 64'd1);
    check("t1_hdr0_core_rstn", 64'(core_rstn), 64'd0);
    send_hdr(16'd2, 0);
    send_ins(0, 10'd0, 0);
    send_ins(1, 10'd1, 0);
    wait_done("t1_done");
    check("t1_core_rstn", 64'(core_rstn), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_writes", 64'(n_writes), 64'd2);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    check("t1_waddr_hold", 64'(bus.ins_waddr), 64'd1);
    check("t1_wdata_hold", 64'(bus.ins_wdata), 64'h0_0010_0013);

    // Whole table with random rx_valid gaps
    w0 = n_writes;
    load_prog(NVEC, 3);
    wait_done("t2_done");
    check("t2_writes", 64'(n_writes - w0), 64'(NVEC));
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Empty program
    w0 = n_writes;
    pulse_start();
    send_hdr(16'd0, 0);
    check("t3_done", 64'(done), 64'd1);
    check("t3_core_rstn", 64'(core_rstn), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_writes", 64'(n_writes - w0), 64'd0);

    // Count one beyond depth
    w0 = n_writes;
    pulse_start();
    send_hdr(16'd1025, 0);
    check("t4_err", 64'(err), 64'd1);
    check("t4_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("t4_busy_done_crst", 64'({busy, done, core_rstn}), 64'd0);
    repeat (3) @(negedge clk);
    check("t4_writes", 64'(n_writes - w0), 64'd0);
    pulse_start();
    check("t4_err_cleared", 64'(err), 64'd0);
    check("t4_hdr0_busy", 64'(busy), 64'd1);
    check("t4_hdr0_rx_ready", 64'(bus.rx_ready), 64'd1);
    send_hdr(16'd0, 0);
    check("t4_done", 64'(done), 64'd1);

    // Full-depth load
    w0 = n_writes;
    load_prog(1024, 0);
    wait_done("t5_done");
    check("t5_writes", 64'(n_writes - w0), 64'd1024);
    check("t5_last_waddr", 64'(bus.ins_waddr), 64'd1023);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-load after the third data byte
    pulse_start();
    send_hdr(16'd3, 0);
    bl = tbl[0].bytes_le;
    for (int j = 0; j < 3; j++) send_byte(bl[j*8 +: 8], 0);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_rst_ctrl", 64'({bus.rx_ready, bus.ins_we, busy, done, err, core_rstn}), 64'd0);
    check("t6_rst_waddr", 64'(bus.ins_waddr), 64'd0);
    check("t6_rst_wdata", 64'(bus.ins_wdata), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_reset_beats_start", 64'({busy, bus.rx_ready}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Reload from addr 0 with a start pulse inside DATA
    pulse_start();
    send_hdr(16'd1, 0);
    bl = tbl[2].bytes_le;
    push_exp(2, 10'd0);
    for (int j = 0; j < 5; j++) begin
      if (j == 2) begin
        pulse_start();
        check("t6_data_start_busy", 64'(busy), 64'd1);
        check("t6_data_start_ready", 64'({bus.rx_ready, done}), 64'b10);
      end
      send_byte(bl[j*8 +: 8], 0);
    end
    wait_done("t6_done");
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    // Start from DONE drops core_rstn immediately and reloads
    pulse_start();
    check("t6_restart_core_rstn", 64'(core_rstn), 64'd0);
    check("t6_restart_busy_done", 64'({busy, done}), 64'b10);
    send_hdr(16'd1, 0);
    send_ins(3, 10'd0, 0);
    wait_done("t6_reload_done");
    check("t6_reload_waddr", 64'(bus.ins_waddr), 64'd0);
    check("t6_reload_sb_empty", 64'(sb.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
